sphere_trace_scheduler: RTL and testbench

SPHERE_TRACE_SCHEDULER -- requirements
Module: sphere_trace_scheduler

---
 rtl/sphere_trace_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_sphere_trace_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sphere_trace_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : sphere_trace_scheduler
// Description : Streams N sphere records through a pipelined tracer, one every
//               II cycles, and keeps the nearest hit for the current pixel.
// Revision    : 1.0 - initial release
// =============================================================================
module sphere_trace_scheduler #(
  parameter int II  = 37,
  parameter int LAT = 53,
  parameter int NW  = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [27:0]   req_init,
  input  logic [30:0]   req_dir,
  input  logic [NW-1:0] req_obj_cnt,
  output logic [NW-1:0] obj_addr,
  input  logic [47:0]   obj_data,
  output logic          trc_rst,
  output logic [27:0]   trc_init,
  output logic [30:0]   trc_dir,
  output logic [47:0]   trc_object,
  input  logic [9:0]    trc_t,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_hit,
  output logic [9:0]    res_t,
  output logic [NW-1:0] res_idx,
  output logic [11:0]   res_color
);

  localparam int c_CYC_MAX = ((1 << NW) - 1) * II + LAT + 1;
  localparam int c_CW      = $clog2(c_CYC_MAX + 1);
  localparam int c_PW      = $clog2(II);
  localparam logic [c_PW-1:0] c_PH_ADDR = c_PW'(II - 3);
  localparam logic [c_PW-1:0] c_PH_LOAD = c_PW'(II - 1);
  localparam logic [c_CW-1:0] c_II      = c_CW'(II);
  localparam logic [c_CW-1:0] c_LAT     = c_CW'(LAT);
  localparam logic [9:0]      c_MISS    = 10'h3FF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_fph;
  logic [27:0]     r_init;
  logic [30:0]     r_dir;
  logic [NW-1:0]   r_n;
  logic [c_CW-1:0] r_cyc;
  logic [c_PW-1:0] r_ph;
  logic [NW-1:0]   r_ld_idx;
  logic [NW-1:0]   r_smp_idx;
  logic [c_CW-1:0] r_smp_cyc;
  logic [11:0]     r_col [0:1];

  logic [NW:0]     w_ld_nxt;
  logic            w_more;
  logic            w_smp;
  logic            w_last;

  assign w_ld_nxt = {1'b0, r_ld_idx} + 1'b1;
  assign w_more   = w_ld_nxt < {1'b0, r_n};
  assign w_smp    = (r_cyc == r_smp_cyc);
  assign w_last   = (r_smp_idx == r_n - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fph      <= 1'b0;
      r_init     <= '0;
      r_dir      <= '0;
      r_n        <= '0;
      r_cyc      <= '0;
      r_ph       <= '0;
      r_ld_idx   <= '0;
      r_smp_idx  <= '0;
      r_smp_cyc  <= '0;
      r_col[0]   <= '0;
      r_col[1]   <= '0;
      req_ready  <= 1'b1;
      obj_addr   <= '0;
      trc_rst    <= 1'b0;
      trc_init   <= '0;
      trc_dir    <= '0;
      trc_object <= '0;
      res_valid  <= 1'b0;
      res_hit    <= 1'b0;
      res_t      <= c_MISS;
      res_idx    <= '0;
      res_color  <= '0;
    end else begin
      obj_addr <= '0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_init    <= req_init;
            r_dir     <= req_dir;
            r_n       <= req_obj_cnt;
            req_ready <= 1'b0;
            if (req_obj_cnt == '0) begin
              res_valid <= 1'b1;
              res_hit   <= 1'b0;
              res_t     <= c_MISS;
              res_idx   <= '0;
              res_color <= '0;
              r_state   <= S_DONE;
            end else begin
              r_fph   <= 1'b0;
              r_state <= S_FETCH;
            end
          end
        end

        // First cycle presents address 0, second captures its record.
        S_FETCH: begin
          if (!r_fph) begin
            r_fph <= 1'b1;
          end else begin
            trc_object <= obj_data;
            r_col[0]   <= obj_data[47:36];
            trc_init   <= r_init;
            trc_dir    <= r_dir;
            res_t      <= c_MISS;
            res_idx    <= '0;
            res_color  <= '0;
            res_hit    <= 1'b0;
            r_cyc      <= '0;
            r_ph       <= '0;
            r_ld_idx   <= '0;
            r_smp_idx  <= '0;
            r_smp_cyc  <= c_LAT;
            trc_rst    <= 1'b1;
            r_state    <= S_RUN;
          end
        end

        S_RUN: begin
          r_cyc <= r_cyc + 1'b1;
          r_ph  <= (r_ph == c_PH_LOAD) ? '0 : r_ph + 1'b1;
          if (r_ph == c_PH_ADDR && w_more)
            obj_addr <= w_ld_nxt[NW-1:0];
          if (r_ph == c_PH_LOAD && w_more) begin
            trc_object          <= obj_data;
            r_col[w_ld_nxt[0]]  <= obj_data[47:36];
            r_ld_idx            <= w_ld_nxt[NW-1:0];
          end
          // Strict compare: equal distances keep the earlier sphere, a miss never wins.
          if (w_smp) begin
            if (trc_t < res_t) begin
              res_t     <= trc_t;
              res_idx   <= r_smp_idx;
              res_color <= r_col[r_smp_idx[0]];
              res_hit   <= 1'b1;
            end
            if (w_last) begin
              trc_rst   <= 1'b0;
              res_valid <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_smp_idx <= r_smp_idx + 1'b1;
              r_smp_cyc <= r_smp_cyc + c_II;
            end
          end
        end

        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sphere_trace_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : tb_sphere_trace_scheduler
// Description : Directed self-checking bench with sphere-table and tracer models.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_sphere_trace_scheduler;

  localparam int II  = 37;
  localparam int LAT = 53;
  localparam int NW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [27:0]   req_init;
  logic [30:0]   req_dir;
  logic [NW-1:0] req_obj_cnt;
  logic [NW-1:0] obj_addr;
  logic [47:0]   obj_data;
  logic          trc_rst;
  logic [27:0]   trc_init;
  logic [30:0]   trc_dir;
  logic [47:0]   trc_object;
  logic [9:0]    trc_t;
  logic          res_valid;
  logic          res_ready;
  logic          res_hit;
  logic [9:0]    res_t;
  logic [NW-1:0] res_idx;
  logic [11:0]   res_color;

  always #5 clk = ~clk;

  sphere_trace_scheduler #(.II(II), .LAT(LAT), .NW(NW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_init(req_init), .req_dir(req_dir), .req_obj_cnt(req_obj_cnt),
    .obj_addr(obj_addr), .obj_data(obj_data),
    .trc_rst(trc_rst), .trc_init(trc_init), .trc_dir(trc_dir), .trc_object(trc_object),
    .trc_t(trc_t),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_t(res_t), .res_idx(res_idx), .res_color(res_color)
  );

  logic [47:0] obj_mem [64];
  logic [9:0]  res_tab [64];

  function automatic logic [11:0] col_of(input int i);
    return 12'(12'h100 + i * 3);
  endfunction

  // Sphere table: one-cycle read latency.
  always @(posedge clk) obj_data <= obj_mem[obj_addr];

  // Tracer: result appears LAT cycles after the first cycle an object is presented.
  logic [9:0]  pipe [LAT];
  logic [47:0] prev_obj;
  logic        prev_rst;
  always @(posedge clk) begin
    prev_obj <= trc_object;
    prev_rst <= trc_rst;
    pipe[0]  <= (trc_rst && (!prev_rst || trc_object != prev_obj)) ? res_tab[trc_object[5:0]] : 10'h3FF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign trc_t = pipe[LAT-1];

  int n_checks = 0;
  int n_errors = 0;
  int addr_v[$];
  int addr_c[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_pixel(input int n, input logic [27:0] ini, input logic [30:0] dir,
                          output int lat, output int op_bad);
    int cyc;
    int k;
    cyc = -1; lat = 99999; op_bad = 0;
    addr_v.delete(); addr_c.delete();
    @(negedge clk);
    req_init = ini; req_dir = dir; req_obj_cnt = NW'(n); req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cyc < 0) begin
        if (trc_rst) cyc = 0;
      end else cyc++;
      if (obj_addr != 0) begin
        addr_v.push_back(int'(obj_addr));
        addr_c.push_back(cyc);
      end
      if (cyc >= 0 && trc_rst) begin
        k = cyc / II;
        if (k > n - 1) k = n - 1;
        if (trc_init !== ini || trc_dir !== dir || trc_object !== obj_mem[k]) op_bad++;
      end
      if (res_valid) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, opb, bad, cyc;
    logic [28:0] snap;
    rst = 1'b0; req_valid = 1'b0; req_init = '0; req_dir = '0; req_obj_cnt = '0; res_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      obj_mem[i] = {col_of(i), 8'(i + 1), 28'(i)};
      res_tab[i] = 10'h3FF;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_trc_rst", trc_rst, 0);
    check_val("rst_obj_addr", obj_addr, 0);
    check_val("rst_res_t", res_t, 10'h3FF);
    check_val("rst_res_hit", res_hit, 0);
    check_val("rst_res_idx", res_idx, 0);
    check_val("rst_res_color", res_color, 0);
    check_val("rst_trc_object", trc_object, 0);
    @(negedge clk) rst = 1'b1;
    repeat (LAT + 2) @(negedge clk);

    // N = 0: immediate miss
    req_obj_cnt = '0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    bad = 0;
    @(negedge clk); if (obj_addr != 0 || trc_rst) bad++;
    @(negedge clk); if (obj_addr != 0 || trc_rst) bad++;
    check_val("n0_no_fetch", bad, 0);
    check_val("n0_valid", res_valid, 1);
    check_val("n0_hit", res_hit, 0);
    check_val("n0_t", res_t, 10'h3FF);
    check_val("n0_idx", res_idx, 0);
    check_val("n0_req_ready", req_ready, 0);
    ack();

    // N = 3, nearest is sphere 1
    res_tab[0] = 10'd120; res_tab[1] = 10'd45; res_tab[2] = 10'd300;
    do_pixel(3, 28'h1234567, 31'h7654321, lat, opb);
    check_val("n3_latency", lat, 128);
    check_val("n3_hit", res_hit, 1);
    check_val("n3_t", res_t, 45);
    check_val("n3_idx", res_idx, 1);
    check_val("n3_color", res_color, col_of(1));
    check_val("n3_operands", opb, 0);
    check_val("n3_trc_rst_off", trc_rst, 0);
    check_val("n3_nreads", addr_v.size(), 2);
    ack();

    // N = 4, all misses; prefetch address timing
    for (int i = 0; i < 64; i++) res_tab[i] = 10'h3FF;
    do_pixel(4, 28'h0ABCDEF, 31'h1357ACE, lat, opb);
    check_val("n4_latency", lat, 3 * II + LAT + 1);
    check_val("n4_hit", res_hit, 0);
    check_val("n4_t", res_t, 10'h3FF);
    check_val("n4_operands", opb, 0);
    check_val("n4_nreads", addr_v.size(), 3);
    if (addr_v.size() == 3) begin
      check_val("n4_addr1", addr_v[0], 1); check_val("n4_addr1_cyc", addr_c[0], 35);
      check_val("n4_addr2", addr_v[1], 2); check_val("n4_addr2_cyc", addr_c[1], 72);
      check_val("n4_addr3", addr_v[2], 3); check_val("n4_addr3_cyc", addr_c[2], 109);
    end
    ack();

    // N = 3, tie keeps the lowest index
    res_tab[0] = 10'd50; res_tab[1] = 10'd50; res_tab[2] = 10'd50;
    do_pixel(3, 28'h0000001, 31'h0000002, lat, opb);
    check_val("tie_latency", lat, 128);
    check_val("tie_hit", res_hit, 1);
    check_val("tie_t", res_t, 50);
    check_val("tie_idx", res_idx, 0);
    check_val("tie_color", res_color, col_of(0));

    // Back-pressure in DONE with a pending request
    snap = {res_hit, res_t, res_idx, res_color};
    req_obj_cnt = '0; req_valid = 1'b1; res_ready = 1'b0; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || {res_hit, res_t, res_idx, res_color} !== snap || req_ready !== 1'b0) bad++;
    end
    check_val("stall_hold", bad, 0);
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    check_val("stall_ack_valid", res_valid, 0);
    check_val("stall_ack_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    check_val("stall_accept_ready", req_ready, 0);
    check_val("stall_accept_valid", res_valid, 1);
    check_val("stall_accept_t", res_t, 10'h3FF);
    ack();

    // Reset mid-run abandons the pixel
    for (int i = 0; i < 5; i++) res_tab[i] = 10'(10 + i);
    @(negedge clk);
    req_obj_cnt = NW'(5); req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cyc < 0) begin
        if (trc_rst) cyc = 0;
      end else cyc++;
      if (cyc == 60) break;
    end
    check_val("rr_reached_cyc60", cyc, 60);
    rst = 1'b0;
    #1;
    check_val("rr_trc_rst", trc_rst, 0);
    check_val("rr_res_valid", res_valid, 0);
    check_val("rr_req_ready", req_ready, 1);
    @(negedge clk) rst = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (res_valid || trc_rst) bad++;
    end
    check_val("rr_no_result", bad, 0);
    res_tab[0] = 10'd7;
    do_pixel(1, 28'h0FFFFFF, 31'h7FFFFFFF, lat, opb);
    check_val("n1_latency", lat, 54);
    check_val("n1_hit", res_hit, 1);
    check_val("n1_t", res_t, 7);
    check_val("n1_color", res_color, col_of(0));
    check_val("n1_nreads", addr_v.size(), 0);
    ack();

    // Maximum object count, nearest is the last sphere
    for (int i = 0; i < 63; i++) res_tab[i] = 10'(1000 - i * 10);
    do_pixel(63, 28'h5A5A5A5, 31'h2A5A5A5A, lat, opb);
    check_val("n63_latency", lat, 62 * II + LAT + 1);
    check_val("n63_hit", res_hit, 1);
    check_val("n63_t", res_t, 380);
    check_val("n63_idx", res_idx, 62);
    check_val("n63_color", res_color, col_of(62));
    check_val("n63_operands", opb, 0);
    check_val("n63_nreads", addr_v.size(), 62);
    if (addr_v.size() == 62) begin
      check_val("n63_last_addr", addr_v[61], 62);
      check_val("n63_last_addr_cyc", addr_c[61], 62 * II - 2);
    end
    ack();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
